// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencing controller: PC/nPC load enables, nPC source select and IF/ID control.
// Optional performance counters are compiled in when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl #(
    parameter int          RESET_HOLD = 2,
    parameter int          WAIT_MAX   = 8,
    parameter logic [31:0] TRAP_VEC   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        R,
    input  logic        imem_ready,
    input  logic        stall_id,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        annul,
    input  logic        trap_req,
    output logic        imem_req,
    output logic        pc_le,
    output logic        npc_le,
    output logic [1:0]  npc_sel,
    output logic [31:0] npc_alt,
    output logic        ifid_le,
    output logic        ifid_clr,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic        mem_timeout
);

    localparam logic [3:0] HOLD_LAST  = 4'(RESET_HOLD - 1);
    localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_BR   = 2'b01;
    localparam logic [1:0] SEL_TRAP = 2'b10;

    typedef enum logic [2:0] {
        S_HOLD,
        S_FETCH,
        S_WAIT,
        S_STALL,
        S_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        annul_pend_q, annul_pend_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_tgt_q, br_tgt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        redirect;
    logic [31:0] redir_tgt;
    logic        redir_annul;

    function automatic logic [7:0] wait_inc(input logic [7:0] cnt);
        return (cnt >= WAIT_MAX_C) ? WAIT_MAX_C : cnt + 8'd1;
    endfunction

    // A redirect is either a fresh taken CTI or one latched while memory was stalling.
    assign redirect    = br_taken | br_pend_q;
    assign redir_tgt   = br_taken ? br_target : br_tgt_q;
    assign redir_annul = br_taken ? annul : annul_pend_q;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        annul_pend_d = annul_pend_q;
        br_pend_d    = br_pend_q;
        br_tgt_d     = br_tgt_q;
        imem_req     = 1'b0;
        pc_le        = 1'b0;
        npc_le       = 1'b0;
        npc_sel      = SEL_SEQ;
        npc_alt      = 32'h0;
        ifid_le      = 1'b0;
        ifid_clr     = 1'b0;

        if (state_q == S_HOLD) begin
            hold_cnt_d = hold_cnt_q + 4'd1;
            if (hold_cnt_q >= HOLD_LAST) begin
                hold_cnt_d = 4'd0;
                state_d    = S_FETCH;
            end
        end else begin
            imem_req = 1'b1;
            if (trap_req) begin
                pc_le        = 1'b1;
                npc_le       = 1'b1;
                npc_sel      = SEL_TRAP;
                npc_alt      = TRAP_VEC;
                ifid_clr     = 1'b1;
                annul_pend_d = 1'b0;
                br_pend_d    = 1'b0;
                wait_cnt_d   = 8'd0;
                state_d      = S_FLUSH;
            end else if (redirect && imem_ready) begin
                // A word arriving after a memory wait belongs to the old path: drop it.
                pc_le        = 1'b1;
                npc_le       = 1'b1;
                npc_sel      = SEL_BR;
                npc_alt      = redir_tgt;
                ifid_clr     = br_pend_q | (state_q == S_WAIT);
                ifid_le      = ~(br_pend_q | (state_q == S_WAIT));
                annul_pend_d = redir_annul;
                br_pend_d    = 1'b0;
                wait_cnt_d   = 8'd0;
                state_d      = redir_annul ? S_FLUSH : S_FETCH;
            end else if (redirect) begin
                br_pend_d    = 1'b1;
                br_tgt_d     = redir_tgt;
                annul_pend_d = redir_annul;
                ifid_clr     = 1'b1;
                wait_cnt_d   = wait_inc(wait_cnt_q);
                state_d      = S_WAIT;
            end else if (state_q == S_FLUSH) begin
                ifid_clr = 1'b1;
                if (imem_ready) begin
                    pc_le        = 1'b1;
                    npc_le       = 1'b1;
                    annul_pend_d = 1'b0;
                    wait_cnt_d   = 8'd0;
                    state_d      = S_FETCH;
                end else begin
                    wait_cnt_d = wait_inc(wait_cnt_q);
                end
            end else if (stall_id) begin
                state_d = S_STALL;
            end else if (!imem_ready) begin
                ifid_clr   = 1'b1;
                wait_cnt_d = wait_inc(wait_cnt_q);
                state_d    = S_WAIT;
            end else begin
                pc_le      = 1'b1;
                npc_le     = 1'b1;
                ifid_le    = 1'b1;
                wait_cnt_d = 8'd0;
                state_d    = S_FETCH;
            end
        end

        if (R) begin
            imem_req = 1'b0;
            pc_le    = 1'b0;
            npc_le   = 1'b0;
            npc_sel  = SEL_SEQ;
            npc_alt  = 32'h0;
            ifid_le  = 1'b0;
            ifid_clr = 1'b0;
        end
    end

    assign mem_timeout_d = mem_timeout_q | (wait_cnt_d >= WAIT_MAX_C);
    assign mem_timeout   = mem_timeout_q;

    always_ff @(posedge clk) begin
        if (R) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= 4'd0;
            wait_cnt_q    <= 8'd0;
            annul_pend_q  <= 1'b0;
            br_pend_q     <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            annul_pend_q  <= annul_pend_d;
            br_pend_q     <= br_pend_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // The latched target is pure data and is only consumed while br_pend_q is set.
    always_ff @(posedge clk) begin
        br_tgt_q <= br_tgt_d;
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] cnt, input logic en);
        return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

    always_comb begin
        perf_fetch_d = sat_inc32(perf_fetch_q, ifid_le);
        perf_stall_d = sat_inc32(perf_stall_q, (state_q == S_STALL) || (state_q == S_WAIT));
        perf_flush_d = sat_inc32(perf_flush_q, ifid_clr);
    end

    always_ff @(posedge clk) begin
        if (R) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a driver pushes model-predicted outputs per cycle,
// a monitor on the falling edge pops and compares against the DUT.
module tb_if_fetch_ctrl;

    localparam int          RESET_HOLD = 2;
    localparam int          WAIT_MAX   = 8;
    localparam logic [31:0] TRAP_VEC   = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        imem_ready = 1'b1;
    logic        stall_id = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        annul = 1'b0;
    logic        trap_req = 1'b0;
    logic        imem_req, pc_le, npc_le, ifid_le, ifid_clr, mem_timeout;
    logic [1:0]  npc_sel;
    logic [31:0] npc_alt;

    typedef struct packed {
        logic        imem_req;
        logic        pc_le;
        logic        npc_le;
        logic [1:0]  sel;
        logic [31:0] alt;
        logic        ifid_le;
        logic        ifid_clr;
        logic        mem_timeout;
    } obs_t;

    obs_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc_no = 0;

    if_fetch_ctrl #(.RESET_HOLD(RESET_HOLD), .WAIT_MAX(WAIT_MAX), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .R(R), .imem_ready(imem_ready), .stall_id(stall_id),
        .br_taken(br_taken), .br_target(br_target), .annul(annul), .trap_req(trap_req),
        .imem_req(imem_req), .pc_le(pc_le), .npc_le(npc_le), .npc_sel(npc_sel),
        .npc_alt(npc_alt), .ifid_le(ifid_le), .ifid_clr(ifid_clr), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: tracks idle cycles left after reset, an owed flush bubble,
    // whether the previous cycle was a memory-wait bubble, a parked redirect and the miss run.
    int          m_idle_left  = RESET_HOLD;
    bit          m_owe_flush  = 0;
    bit          m_after_miss = 0;
    bit          m_parked     = 0;
    logic [31:0] m_park_tgt   = 32'h0;
    bit          m_park_annul = 0;
    int          m_miss_run   = 0;
    bit          m_timeout    = 0;

    task automatic model_step(input bit r, rdy, st, br, input logic [31:0] tgt,
                              input bit an, tr, output obs_t e);
        bit          take_br;
        logic [31:0] dest;
        bit          dest_annul;
        e = '0;
        e.mem_timeout = m_timeout;
        if (r) begin
            m_idle_left = RESET_HOLD; m_owe_flush = 0; m_after_miss = 0;
            m_parked = 0; m_miss_run = 0; m_timeout = 0;
            return;
        end
        if (m_idle_left > 0) begin
            m_idle_left--;
            return;
        end
        e.imem_req = 1;
        take_br    = br || m_parked;
        dest       = br ? tgt : m_park_tgt;
        dest_annul = br ? an : m_park_annul;
        if (tr) begin
            e.pc_le = 1; e.npc_le = 1; e.sel = 2'b10; e.alt = TRAP_VEC; e.ifid_clr = 1;
            m_owe_flush = 1; m_parked = 0; m_miss_run = 0; m_after_miss = 0;
        end else if (take_br && rdy) begin
            e.pc_le = 1; e.npc_le = 1; e.sel = 2'b01; e.alt = dest;
            if (m_parked || m_after_miss) e.ifid_clr = 1; else e.ifid_le = 1;
            m_owe_flush = dest_annul; m_parked = 0; m_miss_run = 0; m_after_miss = 0;
        end else if (take_br) begin
            e.ifid_clr = 1;
            m_parked = 1; m_park_tgt = dest; m_park_annul = dest_annul;
            m_owe_flush = 0; m_after_miss = 1; m_miss_run++;
        end else if (m_owe_flush) begin
            e.ifid_clr = 1;
            m_after_miss = 0;
            if (rdy) begin
                e.pc_le = 1; e.npc_le = 1; m_owe_flush = 0; m_miss_run = 0;
            end else begin
                m_miss_run++;
            end
        end else if (st) begin
            m_after_miss = 0;
        end else if (!rdy) begin
            e.ifid_clr = 1; m_after_miss = 1; m_miss_run++;
        end else begin
            e.pc_le = 1; e.npc_le = 1; e.ifid_le = 1; m_miss_run = 0; m_after_miss = 0;
        end
        if (m_miss_run > WAIT_MAX) m_miss_run = WAIT_MAX;
        if (m_miss_run >= WAIT_MAX) m_timeout = 1;
    endtask

    task automatic cyc(input bit r, rdy, st, br, input logic [31:0] tgt, input bit an, tr);
        obs_t e;
        @(posedge clk);
        #1;
        R = r; imem_ready = rdy; stall_id = st; br_taken = br;
        br_target = tgt; annul = an; trap_req = tr;
        model_step(r, rdy, st, br, tgt, an, tr, e);
        sb.push_back(e);
    endtask

    task automatic run_n(input int n, input bit r, rdy, st);
        for (int i = 0; i < n; i++) cyc(r, rdy, st, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        obs_t e, g;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = '{imem_req, pc_le, npc_le, npc_sel, npc_alt, ifid_le, ifid_clr, mem_timeout};
                n_vec++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got req=%b pc=%b npc=%b sel=%b alt=%h le=%b clr=%b to=%b ; expected req=%b pc=%b npc=%b sel=%b alt=%h le=%b clr=%b to=%b",
                             cyc_no, g.imem_req, g.pc_le, g.npc_le, g.sel, g.alt, g.ifid_le, g.ifid_clr, g.mem_timeout,
                             e.imem_req, e.pc_le, e.npc_le, e.sel, e.alt, e.ifid_le, e.ifid_clr, e.mem_timeout);
                end
            end
        end
    end

    initial begin : stimulus
        int burst;
        bit rdy;
        run_n(3, 1, 1, 0);                                  // reset held
        run_n(8, 0, 1, 0);                                  // hold idle then streaming
        run_n(3, 0, 1, 1);                                  // ID stall
        run_n(3, 0, 1, 0);
        cyc(0, 1, 0, 1, 32'h40, 0, 0);                      // branch, no annul
        run_n(2, 0, 1, 0);
        cyc(0, 1, 0, 1, 32'h44, 1, 0);                      // branch with annul
        run_n(3, 0, 1, 0);
        run_n(10, 0, 0, 0);                                 // memory wait to timeout
        run_n(3, 0, 1, 0);
        cyc(0, 1, 1, 1, 32'h1234, 1, 1);                    // trap + branch + stall
        run_n(3, 0, 1, 0);
        run_n(2, 0, 1, 1);
        cyc(1, 1, 1, 0, 32'h0, 0, 0);                       // reset during stall
        run_n(5, 0, 1, 0);
        run_n(3, 0, 0, 0);
        cyc(1, 0, 0, 0, 32'h0, 0, 0);                       // reset during wait
        run_n(5, 0, 1, 0);
        run_n(2, 0, 0, 0);
        cyc(0, 0, 0, 1, 32'h200, 1, 0);                     // branch during wait
        run_n(1, 0, 0, 0);
        run_n(4, 0, 1, 0);

        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(6, 12);
            if (burst > 0) begin
                rdy = 0; burst--;
            end else begin
                rdy = ($urandom_range(0, 4) != 0);
            end
            cyc($urandom_range(0, 299) == 0, rdy, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1,
                $urandom_range(0, 39) == 0);
        end

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
